exc_commit: RTL and testbench



---
 rtl/exc_commit_pkg.sv | 39 +++
 rtl/exc_commit_if.sv | 41 ++++
 rtl/exc_int_detect.sv | 17 +
 rtl/exc_commit.sv | 78 +++++++
 tb/tb_exc_commit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/exc_commit_pkg.sv
// rtl/exc_commit_pkg.sv - CP0 register selects, excodes, Status/Cause bit positions and FSM state type
package exc_commit_pkg;

  // CP0 selects encoded as {rd, sel}
  localparam logic [7:0] CR_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] CR_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] CR_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] CR_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] CR_EPC     = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return status[STATUS_IE] & ~status[STATUS_EXL]
         & (|(cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]));
  endfunction

endpackage

// File: rtl/exc_commit_if.sv
// rtl/exc_commit_if.sv - WB-stage, CP0 strobe and fetch-redirect signal bundle for exc_commit
interface exc_commit_if;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_bd;
  logic        ws_ex;
  logic [4:0]  ws_excode;
  logic        ws_eret;
  logic        ws_mtc0;
  logic [7:0]  ws_c0_addr;
  logic [31:0] ws_c0_wdata;
  logic [31:0] c0_status;
  logic [31:0] c0_cause;
  logic [31:0] c0_epc;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic        eret_flush;
  logic        mtc0_we;
  logic [7:0]  c0_addr;
  logic [31:0] c0_wdata;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output ws_valid, ws_pc, ws_bd, ws_ex, ws_excode, ws_eret, ws_mtc0,
           ws_c0_addr, ws_c0_wdata, c0_status, c0_cause, c0_epc, redirect_ready,
    input  wb_ex, wb_excode, wb_pc, wb_bd, eret_flush, mtc0_we, c0_addr, c0_wdata,
           pipe_flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  ws_valid, ws_pc, ws_bd, ws_ex, ws_excode, ws_eret, ws_mtc0,
           ws_c0_addr, ws_c0_wdata, c0_status, c0_cause, c0_epc, redirect_ready,
    output wb_ex, wb_excode, wb_pc, wb_bd, eret_flush, mtc0_we, c0_addr, c0_wdata,
           pipe_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_int_detect.sv
// rtl/exc_int_detect.sv - registered interrupt request from Status.IE/EXL/IM and Cause.IP
module exc_int_detect
  import exc_commit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c0_status,
  input  logic [31:0] c0_cause,
  output logic        int_req_r
);

  always_ff @(posedge clk) begin
    if (reset) int_req_r <= 1'b0;
    else       int_req_r <= int_pending(c0_status, c0_cause);
  end

endmodule

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - WB exception/ERET/MTC0 commit and fetch redirect; EXC_INT_EN enables interrupts
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  exc_commit_if.slave bus
);

  state_t      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        int_req_r;
  logic        commit_ok, int_take, wb_ex, eret_flush;

`ifdef EXC_INT_EN
  exc_int_detect u_int_detect (
    .clk       (clk),
    .reset     (reset),
    .c0_status (bus.c0_status),
    .c0_cause  (bus.c0_cause),
    .int_req_r (int_req_r)
  );
`else
  logic unused_c0;
  assign int_req_r = 1'b0;
  assign unused_c0 = ^{bus.c0_status, bus.c0_cause};
`endif

  // WB inputs are ignored entirely while a redirect is outstanding
  assign commit_ok  = bus.ws_valid & (state_q == ST_IDLE);
  assign int_take   = commit_ok & int_req_r;
  assign wb_ex      = commit_ok & (bus.ws_ex | int_take);
  assign eret_flush = commit_ok & bus.ws_eret & ~wb_ex;

  assign bus.wb_ex          = wb_ex;
  assign bus.wb_excode      = int_take ? EXC_INT : bus.ws_excode;
  assign bus.wb_pc          = bus.ws_pc;
  assign bus.wb_bd          = bus.ws_bd;
  assign bus.eret_flush     = eret_flush;
  assign bus.mtc0_we        = commit_ok & bus.ws_mtc0 & ~wb_ex;
  assign bus.c0_addr        = bus.ws_c0_addr;
  assign bus.c0_wdata       = bus.ws_c0_wdata;
  assign bus.pipe_flush     = wb_ex | eret_flush | (state_q == ST_REDIRECT);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_ex) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = EXC_VECTOR;
        end else if (eret_flush) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = bus.c0_epc;
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - directed and random checks of exc_commit against a cycle reference model with a toy CP0
module tb_exc_commit;
  import exc_commit_pkg::*;

`ifdef EXC_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exc_commit_if bus ();

  exc_commit #(.EXC_VECTOR(32'hBFC0_0380)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        v, ex, bd, eret, mtc0, rdy;
  logic [4:0]  code;
  logic [31:0] pc, wdata;
  logic [7:0]  addr;

  logic [31:0] cp_status, cp_cause, cp_epc;

  bit          ref_busy;
  logic [31:0] ref_target;
  bit          ref_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    v = 0; ex = 0; bd = 0; eret = 0; mtc0 = 0; code = 5'h0;
    pc = 32'hBFC0_0000; addr = 8'h0; wdata = 32'h0; rdy = 1; reset = 0;
  endtask

  task automatic step();
    bit ok, take, e_ex, e_eret, e_mtc0;
    logic [4:0] e_code;
    bus.ws_valid = v; bus.ws_pc = pc; bus.ws_bd = bd; bus.ws_ex = ex;
    bus.ws_excode = code; bus.ws_eret = eret; bus.ws_mtc0 = mtc0;
    bus.ws_c0_addr = addr; bus.ws_c0_wdata = wdata;
    bus.c0_status = cp_status; bus.c0_cause = cp_cause; bus.c0_epc = cp_epc;
    bus.redirect_ready = rdy;
    @(negedge clk);
    ok     = v && !ref_busy;
    take   = ok && ref_irq;
    e_ex   = ok && (ex || take);
    e_code = take ? EXC_INT : code;
    e_eret = ok && eret && !e_ex;
    e_mtc0 = ok && mtc0 && !e_ex;
    chk("wb_ex", bus.wb_ex, e_ex);
    chk("wb_excode", bus.wb_excode, e_code);
    chk("wb_pc", bus.wb_pc, pc);
    chk("wb_bd", bus.wb_bd, bd);
    chk("eret_flush", bus.eret_flush, e_eret);
    chk("mtc0_we", bus.mtc0_we, e_mtc0);
    chk("c0_addr", bus.c0_addr, addr);
    chk("c0_wdata", bus.c0_wdata, wdata);
    chk("pipe_flush", bus.pipe_flush, e_ex || e_eret || ref_busy);
    chk("redirect_valid", bus.redirect_valid, ref_busy);
    chk("redirect_pc", bus.redirect_pc, ref_target);
    if (reset) begin
      ref_busy = 0; ref_target = 32'h0; ref_irq = 0;
    end else begin
      ref_irq = INT_EN && cp_status[0] && !cp_status[1] && (|(cp_cause[15:8] & cp_status[15:8]));
      if (ref_busy) begin
        if (rdy) ref_busy = 0;
      end else if (e_ex) begin
        ref_busy = 1; ref_target = 32'hBFC0_0380;
      end else if (e_eret) begin
        ref_busy = 1; ref_target = cp_epc;
      end
      // toy CP0 reacting to the expected strobes at the same edge
      if (e_ex) begin
        cp_status[1] = 1'b1;
        cp_epc = bd ? pc - 32'd4 : pc;
        cp_cause[31] = bd;
        cp_cause[6:2] = e_code;
      end else if (e_eret) begin
        cp_status[1] = 1'b0;
      end else if (e_mtc0) begin
        if (addr == CR_STATUS) cp_status = wdata;
        else if (addr == CR_CAUSE) cp_cause[9:8] = wdata[9:8];
        else if (addr == CR_EPC) cp_epc = wdata;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    cp_status = 32'h0040_0000; cp_cause = 32'h0; cp_epc = 32'h0;
    ref_busy = 0; ref_target = 32'h0; ref_irq = 0;
    idle(); reset = 1;
    bus.ws_valid = 0; bus.ws_pc = 0; bus.ws_bd = 0; bus.ws_ex = 0; bus.ws_excode = 0;
    bus.ws_eret = 0; bus.ws_mtc0 = 0; bus.ws_c0_addr = 0; bus.ws_c0_wdata = 0;
    bus.c0_status = cp_status; bus.c0_cause = cp_cause; bus.c0_epc = cp_epc;
    bus.redirect_ready = 1;
    @(posedge clk); #1;
    reset = 1; step();
    idle(); step();

    // syscall
    v = 1; ex = 1; code = EXC_SYS; pc = 32'hBFC0_1000; step();
    idle(); rdy = 0; step();
    chk("syscall_target", bus.redirect_pc, 32'hBFC0_0380);
    rdy = 1; step();
    idle(); step();

    // ERET followed by 5 cycles of backpressure with a bogus exception in WB
    cp_epc = 32'hBFC0_2004;
    v = 1; eret = 1; pc = 32'hBFC0_1100; step();
    idle(); v = 1; ex = 1; code = EXC_RI; rdy = 0;
    for (int i = 0; i < 5; i++) step();
    chk("eret_target", bus.redirect_pc, 32'hBFC0_2004);
    idle(); step();
    idle(); step();

    // interrupt on IP7 while an MTC0 sits in WB
    v = 1; mtc0 = 1; addr = CR_STATUS; wdata = 32'h0040_8001; step();
    idle(); cp_cause[15] = 1'b1; step();
    v = 1; mtc0 = 1; addr = CR_COMPARE; wdata = 32'h0000_0100; pc = 32'hBFC0_1200; step();
    idle(); step();
    for (int i = 0; i < 4; i++) begin
      idle(); v = 1; pc = 32'hBFC0_1300 + 32'(i * 4); step();
    end
    cp_cause[15] = 1'b0;
    idle(); v = 1; mtc0 = 1; addr = CR_STATUS; wdata = 32'h0040_0000; step();
    idle(); step();

    // MTC0 EPC immediately followed by ERET
    v = 1; mtc0 = 1; addr = CR_EPC; wdata = 32'h0000_1234; step();
    idle(); v = 1; eret = 1; step();
    idle(); rdy = 0; step();
    chk("mtc0_eret_target", bus.redirect_pc, 32'h0000_1234);

    // reset while a redirect is outstanding
    idle(); rdy = 0; reset = 1; step();
    idle(); step();
    chk("reset_redirect_drop", bus.redirect_valid, 1'b0);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      idle();
      v    = $urandom_range(0, 3) != 0;
      ex   = $urandom_range(0, 9) == 0;
      code = 5'($urandom_range(1, 13));
      bd   = $urandom_range(0, 1) == 1;
      pc   = 32'hBFC0_0000 | (32'($urandom_range(0, 4095)) << 2);
      eret = $urandom_range(0, 11) == 0;
      mtc0 = !eret && $urandom_range(0, 4) == 0;
      case ($urandom_range(0, 3))
        0: addr = CR_STATUS;
        1: addr = CR_CAUSE;
        2: addr = CR_EPC;
        default: addr = CR_COMPARE;
      endcase
      wdata = $urandom;
      rdy   = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 15) == 0) cp_cause[15:10] = 6'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1; v = 0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
